// File: rtl/alu_pkg.sv
// Shared ALU opcode encoding, execute-stage state type and opcode class decode.
package alu_pkg;

  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_MUL = 5'd3;
  localparam logic [4:0] OP_MOV = 5'd4;
  localparam logic [4:0] OP_DIV = 5'd5;
  localparam logic [4:0] OP_AND = 5'd9;
  localparam logic [4:0] OP_OR  = 5'd10;
  localparam logic [4:0] OP_XOR = 5'd11;
  localparam logic [4:0] OP_NOT = 5'd12;
  localparam logic [4:0] OP_LDR = 5'd17;
  localparam logic [4:0] OP_STR = 5'd19;
  localparam logic [4:0] OP_JE  = 5'd25;
  localparam logic [4:0] OP_JNE = 5'd26;
  localparam logic [4:0] OP_JG  = 5'd27;
  localparam logic [4:0] OP_JGE = 5'd28;
  localparam logic [4:0] OP_JL  = 5'd29;
  localparam logic [4:0] OP_JLE = 5'd30;

  typedef enum logic [1:0] {StIdle, StExec, StDone} exec_state_t;

  typedef struct packed {
    logic       wb_en;
    logic [1:0] mem;      // bit1 = load, bit0 = store
    logic       jump;
    logic       illegal;
  } op_class_t;

  function automatic op_class_t op_class(input logic [4:0] op);
    op_class_t c;
    c = '0;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_MOV, OP_DIV,
      OP_AND, OP_OR, OP_XOR, OP_NOT:            c.wb_en = 1'b1;
      OP_LDR:                                   c.mem = 2'b10;
      OP_STR:                                   c.mem = 2'b01;
      OP_JE, OP_JNE, OP_JG, OP_JGE, OP_JL, OP_JLE: c.jump = 1'b1;
      default:                                  c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_latency_ctr.sv
// Loadable down-counter; done is high while the count is zero.
module alu_latency_ctr #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// Execute-stage sequencer driving the external alu and registering its result.
// Optional out_flags (Z,N) port is enabled by defining ALU_EXEC_STAGE_FLAGS_EN.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int unsigned N          = 32,
  parameter int unsigned RD_W       = 4,
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_op,
  input  logic [N-1:0]    in_a,
  input  logic [N-1:0]    in_b,
  input  logic [RD_W-1:0] in_rd,
  output logic [4:0]      alu_ctrl,
  output logic [N-1:0]    src_A,
  output logic [N-1:0]    src_B,
  input  logic [N-1:0]    alu_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_result,
  output logic [RD_W-1:0] out_rd,
  output logic            out_wb_en,
  output logic [1:0]      out_mem,
  output logic            out_jump,
`ifdef ALU_EXEC_STAGE_FLAGS_EN
  output logic [1:0]      out_flags,
`endif
  output logic            out_illegal
);

  exec_state_t     state_q, state_d;
  logic            accept;
  logic            capture;
  logic            cnt_done;
  logic [3:0]      lat_m1;
  logic [RD_W-1:0] rd_q;
  op_class_t       cls;
  logic [N-1:0]    result_d;

  assign in_ready  = !flush && ((state_q == StIdle) || ((state_q == StDone) && out_ready));
  assign accept    = in_valid && in_ready;
  assign capture   = (state_q == StExec) && cnt_done;
  assign out_valid = (state_q == StDone);

  assign cls      = op_class(alu_ctrl);
  assign result_d = cls.illegal ? '0 : alu_result;

  always_comb begin
    lat_m1 = 4'd0;
    if (in_op == OP_MUL) begin
      lat_m1 = 4'(MUL_CYCLES - 1);
    end else if (in_op == OP_DIV) begin
      lat_m1 = 4'(DIV_CYCLES - 1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  if (cnt_done) state_d = StDone;
      StDone:  if (out_ready) state_d = accept ? StExec : StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  alu_latency_ctr #(
    .W (4)
  ) u_lat_ctr (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .load     (accept),
    .load_val (lat_m1),
    .en       (state_q == StExec),
    .done     (cnt_done)
  );

  // Drive registers stay put through EXEC and DONE; alu_ctrl parks at 0 when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_ctrl <= '0;
      src_A    <= '0;
      src_B    <= '0;
      rd_q     <= '0;
    end else if (flush) begin
      alu_ctrl <= '0;
    end else if (accept) begin
      alu_ctrl <= in_op;
      src_A    <= in_a;
      src_B    <= in_b;
      rd_q     <= in_rd;
    end else if ((state_q == StDone) && out_ready) begin
      alu_ctrl <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_result  <= '0;
      out_rd      <= '0;
      out_wb_en   <= 1'b0;
      out_mem     <= 2'b00;
      out_jump    <= 1'b0;
      out_illegal <= 1'b0;
    end else if (capture && !flush) begin
      out_result  <= result_d;
      out_rd      <= rd_q;
      out_wb_en   <= cls.wb_en;
      out_mem     <= cls.mem;
      out_jump    <= cls.jump;
      out_illegal <= cls.illegal;
    end
  end

`ifdef ALU_EXEC_STAGE_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_flags <= 2'b00;
    end else if (capture) begin
      out_flags <= {(result_d == '0), result_d[N-1]};
    end
  end
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with a behavioural alu closing the loop.
module tb_alu_exec_stage;

  localparam int N    = 32;
  localparam int RD_W = 4;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [4:0]      in_op, alu_ctrl;
  logic [N-1:0]    in_a, in_b, src_A, src_B, alu_result, out_result;
  logic [RD_W-1:0] in_rd, out_rd;
  logic            out_wb_en, out_jump, out_illegal;
  logic [1:0]      out_mem;
`ifdef ALU_EXEC_STAGE_FLAGS_EN
  logic [1:0]      out_flags;
`endif

  always #5 clk = ~clk;

  alu_exec_stage dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_rd      (in_rd),
    .alu_ctrl   (alu_ctrl),
    .src_A      (src_A),
    .src_B      (src_B),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_wb_en  (out_wb_en),
    .out_mem    (out_mem),
    .out_jump   (out_jump),
`ifdef ALU_EXEC_STAGE_FLAGS_EN
    .out_flags  (out_flags),
`endif
    .out_illegal(out_illegal)
  );

  function automatic logic [N-1:0] alu_model(input logic [4:0] op, input logic [N-1:0] a,
                                             input logic [N-1:0] b);
    case (op)
      5'd1, 5'd17, 5'd19: return a + b;
      5'd2:               return a - b;
      5'd3:               return a * b;
      5'd4:               return b;
      5'd5:               return (b == 0) ? '1 : a / b;
      5'd9:               return a & b;
      5'd10:              return a | b;
      5'd11:              return a ^ b;
      5'd12:              return ~a;
      5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30: return a - b;
      default:            return 32'hdead_beef;
    endcase
  endfunction

  always_comb alu_result = alu_model(alu_ctrl, src_A, src_B);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op from IDLE and waits (bounded) for out_valid; leaves the stage in DONE.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] rd, output int edges);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_rd = rd; out_ready = 1'b0;
    #1;
    check($sformatf("op%0d in_ready before accept", op), 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; in_op = 5'd0; in_a = '0; in_b = '0; in_rd = '0;
    edges = 0;
    while (!out_valid && edges < 20) begin
      check($sformatf("op%0d alu_ctrl held", op), 32'(alu_ctrl), 32'(op));
      check($sformatf("op%0d src_A held", op), src_A, a);
      tick();
      edges++;
    end
  endtask

  task automatic release_done();
    out_ready = 1'b1;
    #1;
    check("in_ready in DONE with out_ready", 32'(in_ready), 32'd1);
    tick();
    out_ready = 1'b0;
    check("out_valid after release", 32'(out_valid), 32'd0);
    check("alu_ctrl parked after release", 32'(alu_ctrl), 32'd0);
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  rd;
    logic [31:0] res;
    logic        wb;
    logic [1:0]  mem;
    logic        jump;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic run_vec(input vec_t v);
    int edges;
    issue(v.op, v.a, v.b, v.rd, edges);
    check($sformatf("op%0d latency", v.op), 32'(edges), 32'(v.lat));
    check($sformatf("op%0d out_result", v.op), out_result, v.res);
    check($sformatf("op%0d out_rd", v.op), 32'(out_rd), 32'(v.rd));
    check($sformatf("op%0d out_wb_en", v.op), 32'(out_wb_en), 32'(v.wb));
    check($sformatf("op%0d out_mem", v.op), 32'(out_mem), 32'(v.mem));
    check($sformatf("op%0d out_jump", v.op), 32'(out_jump), 32'(v.jump));
    check($sformatf("op%0d out_illegal", v.op), 32'(out_illegal), 32'(v.ill));
    check($sformatf("op%0d in_ready stalled", v.op), 32'(in_ready), 32'd0);
    release_done();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    check({tag, " alu_ctrl"}, 32'(alu_ctrl), 32'd0);
    check({tag, " src_A"}, src_A, 32'd0);
    check({tag, " src_B"}, src_B, 32'd0);
    check({tag, " out_result"}, out_result, 32'd0);
    check({tag, " out_rd"}, 32'(out_rd), 32'd0);
    check({tag, " out_class"}, {27'd0, out_wb_en, out_mem, out_jump, out_illegal}, 32'd0);
`ifdef ALU_EXEC_STAGE_FLAGS_EN
    check({tag, " out_flags"}, 32'(out_flags), 32'd0);
`endif
  endtask

  initial begin
    int edges;
    //           op     a            b            rd     res           wb    mem    j     ill   lat
    vecs[0]  = '{5'd1,  32'd5,       32'd7,       4'd3,  32'd12,       1'b1, 2'b00, 1'b0, 1'b0, 1};
    vecs[1]  = '{5'd3,  32'd6,       32'd7,       4'd4,  32'd42,       1'b1, 2'b00, 1'b0, 1'b0, 2};
    vecs[2]  = '{5'd5,  32'd100,     32'd7,       4'd5,  32'd14,       1'b1, 2'b00, 1'b0, 1'b0, 8};
    vecs[3]  = '{5'd7,  32'd3,       32'd4,       4'd6,  32'd0,        1'b0, 2'b00, 1'b0, 1'b1, 1};
    vecs[4]  = '{5'd17, 32'h100,     32'd4,       4'd7,  32'h104,      1'b0, 2'b10, 1'b0, 1'b0, 1};
    vecs[5]  = '{5'd19, 32'h200,     32'd8,       4'd8,  32'h208,      1'b0, 2'b01, 1'b0, 1'b0, 1};
    vecs[6]  = '{5'd25, 32'd5,       32'd5,       4'd9,  32'd0,        1'b0, 2'b00, 1'b1, 1'b0, 1};
    vecs[7]  = '{5'd2,  32'd9,       32'd4,       4'd10, 32'd5,        1'b1, 2'b00, 1'b0, 1'b0, 1};
    vecs[8]  = '{5'd11, 32'h0000f0f0, 32'h00000ff0, 4'd11, 32'h0000ff00, 1'b1, 2'b00, 1'b0, 1'b0, 1};
    vecs[9]  = '{5'd31, 32'd1,       32'd2,       4'd12, 32'd0,        1'b0, 2'b00, 1'b0, 1'b1, 1};
    vecs[10] = '{5'd2,  32'd3,       32'd4,       4'd15, 32'hffffffff, 1'b1, 2'b00, 1'b0, 1'b0, 1};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_rd = '0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure then back-to-back accept from DONE
    issue(5'd1, 32'd1, 32'd2, 4'd1, edges);
    for (int k = 0; k < 5; k++) begin
      check("stall out_valid", 32'(out_valid), 32'd1);
      check("stall out_result", out_result, 32'd3);
      check("stall in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b1; in_op = 5'd2; in_a = 32'd9; in_b = 32'd4; in_rd = 4'd2; out_ready = 1'b1;
    #1;
    check("b2b in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("b2b exec out_valid", 32'(out_valid), 32'd0);
    check("b2b exec alu_ctrl", 32'(alu_ctrl), 32'd2);
    tick();
    check("b2b out_valid", 32'(out_valid), 32'd1);
    check("b2b out_result", out_result, 32'd5);
    check("b2b out_rd", 32'(out_rd), 32'd2);
    tick();
    out_ready = 1'b0;
    check("b2b drained", 32'(out_valid), 32'd0);

    // Flush in the 4th EXEC cycle of a DIV, with a competing op offered
    in_valid = 1'b1; in_op = 5'd5; in_a = 32'd100; in_b = 32'd7; in_rd = 4'd5;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("div still busy", 32'(out_valid), 32'd0);
    flush = 1'b1; in_valid = 1'b1; in_op = 5'd1; in_a = 32'd1; in_b = 32'd1;
    #1;
    check("flush in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush out_valid", 32'(out_valid), 32'd0);
    check("flush alu_ctrl", 32'(alu_ctrl), 32'd0);
    #1;
    check("post-flush in_ready", 32'(in_ready), 32'd1);
    tick();
    check("flushed op not accepted", 32'(out_valid), 32'd0);

    // Flush in DONE drops the result even with out_ready high
    issue(5'd1, 32'd2, 32'd2, 4'd1, edges);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    check("flush done out_valid", 32'(out_valid), 32'd0);
    tick();
    check("flush done stays idle", 32'(out_valid), 32'd0);

    // Reset while holding a result
    issue(5'd3, 32'd6, 32'd7, 4'd9, edges);
    check("pre-rst out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    check_reset_outputs("rst in DONE");
    rst = 1'b0;

`ifdef ALU_EXEC_STAGE_FLAGS_EN
    issue(5'd2, 32'd3, 32'd3, 4'd1, edges);
    check("flags zero", 32'(out_flags), 32'd2);
    release_done();
    issue(5'd2, 32'd3, 32'd4, 4'd1, edges);
    check("flags negative", 32'(out_flags), 32'd1);
    release_done();
`endif

    run_vec(vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute-stage sequencer that sits directly upstream of the combinational alu and also consumes its result.
- Accepts decoded operations from the decode stage over a valid/ready handshake and registers the opcode and operands.
- Drives alu_ctrl/src_A/src_B and holds them stable for a per-op latency (multi-cycle budget for MUL/DIV).
- Captures alu_result into an output register presented to the memory/writeback stage over a second valid/ready handshake.

Parameters:
- N, 32, datapath width; must match the alu's N.
- RD_W, 4, destination register index width.
- MUL_CYCLES, 2, EXEC cycles granted to opcode 3 (MUL); legal range 1..15.
- DIV_CYCLES, 8, EXEC cycles granted to opcode 5 (DIV); legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous kill of the in-flight op and the held output.
- in_valid  in  1  decode presents an op.
- in_ready  out  1  stage can accept an op this cycle.
- in_op  in  5  ALU opcode, same encoding as the alu's alu_ctrl.
- in_a  in  N  operand A.
- in_b  in  N  operand B.
- in_rd  in  RD_W  destination register.
- alu_ctrl  out  5  to alu.
- src_A  out  N  to alu.
- src_B  out  N  to alu.
- alu_result  in  N  from alu.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_result  out  N  captured result.
- out_rd  out  RD_W  destination register.
- out_wb_en  out  1  op writes the register file (opcodes 1-5, 9-12).
- out_mem  out  2  bit1 = load (17), bit0 = store (19); out_result is the address.
- out_jump  out  1  op is a conditional jump (25-30).
- out_illegal  out  1  opcode is not one of the alu's defined codes; out_result = 0.

Behaviour:
- Clocking and reset: one clock (clk). rst is synchronous and active-high; it has priority over flush, and flush has priority over the handshakes.
- Reset values: state=IDLE, in_ready=1, out_valid=0, alu_ctrl=0, src_A=0, src_B=0, out_result=0, out_rd=0, out_wb_en=0, out_mem=0, out_jump=0, out_illegal=0, cnt=0.
- States: IDLE, EXEC, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational and never depends on in_valid.
- Accept: in_valid && in_ready at an edge.
  - Latch in_op, in_a and in_b into the alu drive registers, and latch in_rd.
  - Load cnt = L-1, where L = MUL_CYCLES for opcode 3, DIV_CYCLES for opcode 5, and 1 for all other opcodes.
  - Go to EXEC.
- EXEC:
  - alu_ctrl/src_A/src_B are held constant.
  - Edge with cnt>0: decrement cnt.
  - Edge with cnt==0: capture alu_result into out_result, register the decoded class bits, go to DONE.
- Latency: out_valid rises at the L-th edge after the accepting edge. Examples: ADD, 1 edge; MUL, 2 edges by default.
- DONE:
  - out_valid=1; all out_* and alu drive registers are held stable until out_ready.
  - out_ready && in_valid: accept the new op and go to EXEC (back-to-back, no IDLE bubble).
  - out_ready && !in_valid: go to IDLE and drive alu_ctrl=0.
- Class decode is a pure function of the registered opcode. Undefined codes (0, 6-8, 13-16, 18, 20-24, 31) take L=1, out_illegal=1, out_result=0, and all other class bits 0.
- flush:
  - At the edge: state=IDLE, out_valid=0, alu_ctrl=0, cnt=0.
  - An in_valid in the same cycle is not accepted (in_ready is forced low while flush=1).
  - A result in DONE is discarded even if out_ready=1 that cycle.
- rst mid-EXEC or in DONE: all outputs return to their reset values at that edge; no partial result is emitted.
- Widths:
  - cnt is 4 bits.
  - out_result is a copy of alu_result with no extension or truncation.

Optional Feature:
- Macro: ALU_EXEC_STAGE_FLAGS_EN.
- When defined:
  - Adds output out_flags, 2 bits: bit1 = Z (out_result==0), bit0 = N (out_result[N-1]).
  - out_flags is registered at the capture edge together with out_result.
  - Reset value is 2'b00; it is cleared by flush.
- When undefined: the port and its logic are absent.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD=1, OP_SUB=2, OP_MUL=3, OP_MOV=4, OP_DIV=5, OP_AND=9, OP_OR=10, OP_XOR=11, OP_NOT=12, OP_LDR=17, OP_STR=19, OP_JE=25..OP_JLE=30;
  - the state enum typedef exec_state_t;
  - a function op_class() returning struct op_class_t {wb_en, mem[1:0], jump, illegal}.
- One sub-module, alu_latency_ctr: loadable down-counter with a done output.
- The alu itself is instantiated one level up, not inside this block.

Test Plan:
- Reset then ADD (op=1, a=5, b=7, rd=3), out_ready=1 -> out_valid one edge after accept, out_result=12, out_rd=3, out_wb_en=1, in_ready=1 during that DONE cycle.
- MUL (op=3, a=6, b=7) with default params -> alu_ctrl=3 held 2 cycles, out_valid at 2nd edge, out_result=42; DIV (op=5, a=100, b=7) -> out_valid at 8th edge, out_result=14.
- out_ready=0 for 5 cycles after ADD result -> out_result/out_valid stable, in_ready=0; on out_ready=1 with a queued SUB (9-4) -> SUB accepted the same edge, result 5 one edge later.
- flush asserted in DIV's 4th EXEC cycle with in_valid=1 -> next edge out_valid=0, state IDLE, new op not accepted; following cycle in_ready=1.
- op=7 (undefined), a=3, b=4 -> out_illegal=1, out_result=0, out_wb_en=0; op=17, a=0x100, b=4 -> out_mem=2'b10, out_result=0x104.
- rst asserted during DONE -> all outputs equal reset values next edge; with ALU_EXEC_STAGE_FLAGS_EN, SUB 3-3 gives out_flags=2'b10 and SUB 3-4 gives 2'b01.
